// File: rtl/majority_pkg.sv
// majority_pkg: shared definitions for the TMR majority voter.
//   LANE_A/LANE_B/LANE_C : bit positions of each lane inside a dissent mask
//   lane_mask_t          : 3-bit per-lane flag vector (bit i = lane i)
//   maj3()               : 1-bit 2-of-3 majority
package majority_pkg;

  localparam int LANE_A = 0;
  localparam int LANE_B = 1;
  localparam int LANE_C = 2;

  typedef logic [2:0] lane_mask_t;

  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (y & z) | (x & z);
  endfunction

endpackage

// File: rtl/majority_bit.sv
// majority_bit: combinational 2-of-3 voter for a single bit position.
//   x, y, z : lane A/B/C bit
//   maj     : majority of x, y, z
//   dissent : per-lane flag, set when that lane disagrees with maj
module majority_bit
  import majority_pkg::*;
(
  input  logic       x,
  input  logic       y,
  input  logic       z,
  output logic       maj,
  output lane_mask_t dissent
);

  always_comb begin
    maj             = maj3(x, y, z);
    // A 3-way tie is impossible, so at most one of these is set.
    dissent         = '0;
    dissent[LANE_A] = x ^ maj;
    dissent[LANE_B] = y ^ maj;
    dissent[LANE_C] = z ^ maj;
  end

endmodule

// File: rtl/majority_voter.sv
// majority_voter: registered three-lane bitwise majority voter for TMR.
//   clk, rst    : rising-edge clock, synchronous active-high reset
//   in_valid    : a/b/c carry a sample this cycle
//   a, b, c     : lane 0/1/2 data, WIDTH bits each
//   out_valid   : f/dissent valid this cycle (1-cycle latency)
//   f           : bitwise majority of a, b, c
//   dissent     : bit i set when lane i differed from f in any bit
//   dissent_cnt : saturating count of dissenting samples; present only when
//                 the macro MAJORITY_DISSENT_CNT_EN is defined
module majority_voter
  import majority_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic             out_valid,
  output logic [WIDTH-1:0] f,
`ifdef MAJORITY_DISSENT_CNT_EN
  output logic [2:0]       dissent,
  output logic [CNT_W-1:0] dissent_cnt
`else
  output logic [2:0]       dissent
`endif
);

  logic [WIDTH-1:0] maj_vec_p0;
  lane_mask_t       bit_dis_p0 [WIDTH];
  lane_mask_t       dissent_vec_p0;

  for (genvar k = 0; k < WIDTH; k++) begin : g_bit
    majority_bit u_bit (
      .x       (a[k]),
      .y       (b[k]),
      .z       (c[k]),
      .maj     (maj_vec_p0[k]),
      .dissent (bit_dis_p0[k])
    );
  end

  // Different bits may blame different lanes, so the masks are OR-ed.
  always_comb begin
    dissent_vec_p0 = '0;
    for (int k = 0; k < WIDTH; k++) begin
      dissent_vec_p0 = dissent_vec_p0 | bit_dis_p0[k];
    end
  end

  // ---- stage p0 -> p1 register ----
  logic             vld_p1_d,     vld_p1_q;
  logic [WIDTH-1:0] f_p1_d,       f_p1_q;
  lane_mask_t       dissent_p1_d, dissent_p1_q;

  // Lanes are only looked at when in_valid is high, so idle X/Z on the
  // inputs cannot reach the held outputs.
  always_comb begin
    vld_p1_d     = in_valid;
    f_p1_d       = f_p1_q;
    dissent_p1_d = dissent_p1_q;
    if (in_valid) begin
      f_p1_d       = maj_vec_p0;
      dissent_p1_d = dissent_vec_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q     <= 1'b0;
      f_p1_q       <= '0;
      dissent_p1_q <= '0;
    end else begin
      vld_p1_q     <= vld_p1_d;
      f_p1_q       <= f_p1_d;
      dissent_p1_q <= dissent_p1_d;
    end
  end

  assign out_valid = vld_p1_q;
  assign f         = f_p1_q;
  assign dissent   = dissent_p1_q;

`ifdef MAJORITY_DISSENT_CNT_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [CNT_W-1:0] cnt_p1_d, cnt_p1_q;

  always_comb begin
    cnt_p1_d = cnt_p1_q;
    if (in_valid && (|dissent_vec_p0)) begin
      cnt_p1_d = sat_inc(cnt_p1_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_p1_q <= '0;
    end else begin
      cnt_p1_q <= cnt_p1_d;
    end
  end

  assign dissent_cnt = cnt_p1_q;
`endif

endmodule

// File: tb/tb_majority_voter.sv
// tb_majority_voter: directed-vector bench for majority_voter.
// Two instances share clk/rst/in_valid: u1 (WIDTH=1) and u4 (WIDTH=4).
// The counter instance uses CNT_W=2 so saturation is reached quickly.
module tb_majority_voter;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [0:0] a1, b1, c1;
  logic [3:0] a4, b4, c4;
  logic       ov1, ov4;
  logic [0:0] f1;
  logic [3:0] f4;
  logic [2:0] d1, d4;
  logic [1:0] cnt1, cnt4;

  int n_tests = 0;
  int n_fail  = 0;

  majority_voter #(.WIDTH(1), .CNT_W(2)) u1 (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .a           (a1),
    .b           (b1),
    .c           (c1),
    .out_valid   (ov1),
    .f           (f1),
`ifdef MAJORITY_DISSENT_CNT_EN
    .dissent     (d1),
    .dissent_cnt (cnt1)
`else
    .dissent     (d1)
`endif
  );

  majority_voter #(.WIDTH(4), .CNT_W(2)) u4 (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .a           (a4),
    .b           (b4),
    .c           (c4),
    .out_valid   (ov4),
    .f           (f4),
`ifdef MAJORITY_DISSENT_CNT_EN
    .dissent     (d4),
    .dissent_cnt (cnt4)
`else
    .dissent     (d4)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle past it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Truth-table expectations indexed by {a,b,c}.
  logic       tt_f [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [2:0] tt_d [8] = '{3'b000, 3'b100, 3'b010, 3'b001,
                           3'b001, 3'b010, 3'b100, 3'b000};

  initial begin
    logic [2:0] v;
    rst = 1'b1; in_valid = 1'b1;
    a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
    a4 = '0; b4 = '0; c4 = '0;

    // Reset held 2 cycles with a valid all-ones sample present.
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_ov", 64'(ov1), 64'd0);
      check("rst_f", 64'(f1), 64'd0);
      check("rst_d", 64'(d1), 64'd0);
    end
`ifdef MAJORITY_DISSENT_CNT_EN
    check("rst_cnt", 64'(cnt1), 64'd0);
`endif
    rst = 1'b0;
    tick();
    check("post_rst_ov", 64'(ov1), 64'd1);
    check("post_rst_f", 64'(f1), 64'd1);

    // WIDTH=1 truth table.
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      a1 = v[2]; b1 = v[1]; c1 = v[0];
      tick();
      check($sformatf("tt_f_%0d", i), 64'(f1), 64'(tt_f[i]));
      check($sformatf("tt_d_%0d", i), 64'(d1), 64'(tt_d[i]));
      check($sformatf("tt_ov_%0d", i), 64'(ov1), 64'd1);
    end

    // WIDTH=4 multi-bit vectors.
    a4 = 4'b1100; b4 = 4'b1010; c4 = 4'b0110;
    tick();
    check("mb1_f", 64'(f4), 64'h0e);
    check("mb1_d", 64'(d4), 64'b111);
    a4 = 4'b1111; b4 = 4'b1111; c4 = 4'b0000;
    tick();
    check("mb2_f", 64'(f4), 64'h0f);
    check("mb2_d", 64'(d4), 64'b100);
    a4 = 4'b0101; b4 = 4'b0000; c4 = 4'b0001;
    tick();
    check("mb3_f", 64'(f4), 64'h01);
    check("mb3_d", 64'(d4), 64'b011);

    // Hold: one valid sample, then idle cycles with changing lanes.
    a1 = 1'b1; b1 = 1'b1; c1 = 1'b0;
    tick();
    check("hold_ov0", 64'(ov1), 64'd1);
    check("hold_f0", 64'(f1), 64'd1);
    check("hold_d0", 64'(d1), 64'b100);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a1 = 1'($urandom); b1 = 1'($urandom); c1 = 1'($urandom);
      a4 = 4'($urandom); b4 = 4'($urandom); c4 = 4'($urandom);
      tick();
      check("hold_ov", 64'(ov1), 64'd0);
      check("hold_f", 64'(f1), 64'd1);
      check("hold_d", 64'(d1), 64'b100);
      check("hold_f4", 64'(f4), 64'h01);
      check("hold_d4", 64'(d4), 64'b011);
    end

    // Back-to-back alternating 111 / 000.
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      a1 = 1'(i % 2 == 0); b1 = a1; c1 = a1;
      tick();
      check("b2b_f", 64'(f1), 64'(i % 2 == 0));
      check("b2b_ov", 64'(ov1), 64'd1);
      check("b2b_d", 64'(d1), 64'd0);
    end

    // Reset mid-stream overrides a valid dissenting sample.
    a1 = 1'b1; b1 = 1'b0; c1 = 1'b1;
    rst = 1'b1;
    tick();
    check("mid_rst_ov", 64'(ov1), 64'd0);
    check("mid_rst_f", 64'(f1), 64'd0);
    check("mid_rst_d", 64'(d1), 64'd0);
    rst = 1'b0;

`ifdef MAJORITY_DISSENT_CNT_EN
    // Counter: lane a dissents every sample; CNT_W=2 saturates at 3.
    a1 = 1'b1; b1 = 1'b0; c1 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("cnt_%0d", i), 64'(cnt1), 64'((i < 3) ? i + 1 : 3));
    end
    rst = 1'b1;
    tick();
    check("cnt_rst", 64'(cnt1), 64'd0);
    rst = 1'b0;
    // Idle dissenting lanes and agreeing valid samples do not count.
    in_valid = 1'b0;
    tick();
    in_valid = 1'b1; a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
    tick();
    check("cnt_nocount", 64'(cnt1), 64'd0);
    a1 = 1'b1;
    tick();
    check("cnt_one", 64'(cnt1), 64'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
